// File: rtl/number_source_if.sv
// Bus bundle for number_source: load side, consumer request and the
// registered delivery/status outputs.
interface number_source_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                    wrEn;
    logic signed [WIDTH-1:0] wrData;
    logic                    readData;
    logic signed [WIDTH-1:0] dataOut;
    logic                    dataValid;
    logic                    lastWord;
    logic                    underflow;
    logic                    overflow;
    logic                    full;
    logic                    empty;
    logic [LW-1:0]           level;
    logic signed [31:0]      cnt;

    modport master (
        output wrEn, wrData, readData,
        input  dataOut, dataValid, lastWord, underflow, overflow,
               full, empty, level, cnt
    );

    modport slave (
        input  wrEn, wrData, readData,
        output dataOut, dataValid, lastWord, underflow, overflow,
               full, empty, level, cnt
    );
endinterface

// File: rtl/number_source.sv
// number_source: circular FIFO of signed numbers delivered on request with
// one cycle of latency, plus underflow/overflow pulses and a delivery count.
module number_source #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    number_source_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [LW-1:0]           level_r;
    logic                    rd_acc;
    logic                    wr_acc;
    logic                    is_full;
    logic                    is_empty;

    assign is_full  = (level_r == FULL_LVL);
    assign is_empty = (level_r == '0);

    // A read frees a slot at the same edge, so a write into a full FIFO is
    // allowed when a read is accepted alongside it; no bypass when empty.
    assign rd_acc = bus.readData && !is_empty;
    assign wr_acc = bus.wrEn && (!is_full || rd_acc);

    assign bus.full  = is_full;
    assign bus.empty = is_empty;
    assign bus.level = level_r;

    // Storage array; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.wrData;
        end
    end

    // Pointers and fill level; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Registered delivery and event pulses; dataOut holds between deliveries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dataOut   <= '0;
            bus.dataValid <= 1'b0;
            bus.lastWord  <= 1'b0;
            bus.underflow <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.cnt       <= '0;
        end else begin
            bus.dataValid <= rd_acc;
            bus.lastWord  <= rd_acc && (level_r == LW'(1)) && !wr_acc;
            bus.underflow <= bus.readData && is_empty;
            bus.overflow  <= bus.wrEn && !wr_acc;
            if (rd_acc) begin
                bus.dataOut <= mem[rd_ptr];
                bus.cnt     <= bus.cnt + 32'sd1;
            end
        end
    end
endmodule

// File: tb/tb_number_source.sv
// Scoreboard bench for number_source: a queue-based reference model predicts
// deliveries and status; a negedge monitor pops and compares.
module tb_number_source;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    typedef struct {
        int data;
        bit last;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    number_source_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    number_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mq[$];
    exp_t exp_q[$];
    int   mcnt      = 0;
    int   last_out  = 0;
    int   exp_level = 0;
    bit   exp_dv    = 1'b0;
    bit   exp_uf    = 1'b0;
    bit   exp_of    = 1'b0;
    bit   mon_en    = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: drive inputs, let the edge happen, update the model.
    task automatic step(input bit we, input int wd, input bit rd);
        bit   rok;
        bit   wok;
        exp_t e;
        bus.wrEn     = we;
        bus.wrData   = wd;
        bus.readData = rd;
        @(posedge clk);
        rok    = rd && (mq.size() != 0);
        wok    = we && ((mq.size() < DEPTH) || rok);
        exp_dv = rok;
        exp_uf = rd && !rok;
        exp_of = we && !wok;
        if (rok) begin
            e.data   = mq.pop_front();
            mcnt     = mcnt + 1;
            e.last   = (mq.size() == 0) && !wok;
            e.cnt    = mcnt;
            last_out = e.data;
            exp_q.push_back(e);
        end
        if (wok) mq.push_back(wd);
        exp_level = mq.size();
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        mcnt      = 0;
        last_out  = 0;
        exp_level = 0;
        exp_dv    = 1'b0;
        exp_uf    = 1'b0;
        exp_of    = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_dataOut",   bus.dataOut,   0);
        chk("rst_dataValid", bus.dataValid, 0);
        chk("rst_lastWord",  bus.lastWord,  0);
        chk("rst_underflow", bus.underflow, 0);
        chk("rst_overflow",  bus.overflow,  0);
        chk("rst_level",     bus.level,     0);
        chk("rst_cnt",       bus.cnt,       0);
        chk("rst_empty",     bus.empty,     1);
        chk("rst_full",      bus.full,      0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a word.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            chk("dataValid", bus.dataValid, exp_dv);
            if (bus.dataValid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_delivery: got dataOut %0d expected none", bus.dataOut);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dataOut",  bus.dataOut,  e.data);
                    chk("lastWord", bus.lastWord, e.last);
                    chk("cnt",      bus.cnt,      e.cnt);
                end
            end else begin
                chk("dataOut_hold", bus.dataOut,  last_out);
                chk("lastWord_idle", bus.lastWord, 0);
            end
            chk("underflow", bus.underflow, exp_uf);
            chk("overflow",  bus.overflow,  exp_of);
            chk("level",     bus.level,     exp_level);
            chk("full",      bus.full,      exp_level == DEPTH);
            chk("empty",     bus.empty,     exp_level == 0);
        end
    end

    initial begin
        bus.wrEn     = 1'b0;
        bus.wrData   = '0;
        bus.readData = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Read on empty, then simultaneous read+write while empty, then 42.
        step(0, 0, 1);
        step(1, 42, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Three writes then three reads; lastWord only with 100.
        step(1, -5, 0);
        step(1, 7, 0);
        step(1, 100, 0);
        repeat (3) step(0, 0, 1);
        step(0, 0, 0);

        // Fill, overflow attempt with 99, drain.
        for (int i = 0; i < DEPTH; i++) step(1, i, 0);
        step(1, 99, 0);
        step(0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1);
        step(0, 0, 0);

        // Full FIFO with simultaneous read and write of 200.
        for (int i = 0; i < DEPTH; i++) step(1, i + 1000, 0);
        step(1, 200, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Reset asserted between edges while words are pending.
        for (int i = 0; i < 4; i++) step(1, i + 50, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        bus.readData = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 1);
        step(0, 0, 0);

        // Randomized traffic with shifting write/read bias.
        for (int blk = 0; blk < 8; blk++) begin
            int wp;
            int rp;
            wp = (blk % 2 == 0) ? 80 : 25;
            rp = (blk % 2 == 0) ? 25 : 80;
            if (blk >= 6) begin
                wp = 55;
                rp = 55;
            end
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(0, 99) < wp, int'($urandom), $urandom_range(0, 99) < rp);
            end
        end
        step(0, 0, 0);
        step(0, 0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/number_source.md
NUMBER_SOURCE -- requirements
Module: number_source

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each stored and delivered number (signed).
REQ-002 Parameter DEPTH, default 16, number of FIFO entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wrEn  input  1  load strobe; pushes wrData when asserted at a rising edge.
REQ-006 wrData  input  WIDTH  signed number to store.
REQ-007 readData  input  1  consumer request for the next number, sampled at a rising edge.
REQ-008 dataOut  output  WIDTH  signed delivered number, registered.
REQ-009 dataValid  output  1  one-cycle pulse qualifying dataOut.
REQ-010 lastWord  output  1  high with dataValid when the delivered word left the FIFO empty.
REQ-011 underflow  output  1  one-cycle pulse: readData seen while empty.
REQ-012 overflow  output  1  one-cycle pulse: wrEn seen while full and no read accepted.
REQ-013 full  output  1  level equals DEPTH.
REQ-014 empty  output  1  level equals 0.
REQ-015 level  output  clog2(DEPTH)+1  number of stored words.
REQ-016 cnt  output  32  signed count of words delivered since reset.

Function
REQ-017 Storage SHALL be a circular FIFO with read and write pointers of clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-018 Read accept: readData=1 and empty=0 at edge N -> head word popped, dataOut=head word and dataValid=1 during cycle N+1 (latency 1).
REQ-019 dataValid SHALL be high for exactly one cycle per accepted read; readData held high SHALL deliver one word per cycle until empty.
REQ-020 dataOut SHALL hold its last delivered value when dataValid=0.
REQ-021 Read reject: readData=1 and empty=1 at edge N -> underflow=1 in cycle N+1, dataValid=0, no pointer/cnt change.
REQ-022 Write accept: wrEn=1 and (full=0 or a read is accepted at the same edge) -> wrData written at write pointer, pointer advanced.
REQ-023 Write reject: wrEn=1, full=1, no accepted read -> data dropped, overflow=1 next cycle, state unchanged.
REQ-024 Simultaneous wrEn and readData while empty: no bypass; read rejected (underflow), write accepted, level becomes 1.
REQ-025 Simultaneous accepted read and write while full or partly filled: both take effect, level unchanged, order preserved.
REQ-026 level SHALL change by +1 (write only), -1 (read only) or 0; full/empty derived combinationally from registered level.
REQ-027 lastWord SHALL be 1 with dataValid when the pop made level 0 and no write was accepted at the same edge; else 0.
REQ-028 cnt SHALL increment by 1 per accepted read, two's-complement wrap from 2147483647 to -2147483648.
REQ-029 dataOut sign SHALL be preserved exactly as written (no truncation or extension inside the block).

Reset
REQ-030 rst=1 SHALL immediately, without clock: pointers=0, level=0, cnt=0, dataOut=0, dataValid=0, lastWord=0, underflow=0, overflow=0, empty=1, full=0.
REQ-031 Reset asserted mid-delivery SHALL cancel any pending dataValid; FIFO contents are discarded logically.
REQ-032 After rst falls, first edge SHALL accept wrEn/readData normally.

Verification
REQ-033 Write -5, 7, 100 on consecutive cycles, then readData 3 cycles -> dataOut -5, 7, 100 one cycle after each request, dataValid 3 cycles, lastWord only with 100, cnt=3, empty=1.
REQ-034 Fill 16 words 0..15, write 99 with no read -> overflow pulse, level=16, full=1; read all -> 0..15 delivered, 99 never seen.
REQ-035 readData on empty after reset -> underflow one cycle, dataValid=0, dataOut=0, cnt=0; same edge with wrEn=42 -> level=1, next read returns 42.
REQ-036 Full FIFO, wrEn=200 and readData same edge -> head delivered, level stays 16, 200 delivered last after 15 more reads; pointers wrap cleanly.
REQ-037 Load 4 words, read 2, assert rst between edges -> outputs zero at once, level=0; after release, read -> underflow, cnt=0.
REQ-038 Force cnt near 2147483647 via 2^31-1 reads (or shortened run with WIDTH check) -> next accepted read gives cnt=-2147483648.
